cdc_4phase_src_arbiter: RTL and testbench

- Single-clock N-to-1 round-robin arbiter in the source domain of a 4-phase CDC.
- Shares one CDC source channel (valid/ready/data) between NumReq requesters.
- Registers the winning item and tags it with the requester index for dst-side demux.
- Holds each presented item stable until it is consumed, which the CDC source half requires.

---
 rtl/cdc_4phase_src_arbiter.sv | 133 +++++++++++++
 tb/tb_cdc_4phase_src_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_4phase_src_arbiter.sv
// cdc_4phase_src_arbiter: round-robin N-to-1 arbiter in the source domain of a 4-phase CDC.
// Registers the winning payload, tags it with the requester index, and holds it until consumed.
// Optional per-requester accept counters are enabled by defining CDC_4PHASE_ARB_STATS_EN.
module cdc_4phase_src_arbiter #(
    parameter int unsigned  NumReq    = 4,
    parameter int unsigned  DataWidth = 32,
    localparam int unsigned IdxWidth  = $clog2(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DataWidth-1:0]        out_data_o,
    output logic [IdxWidth-1:0]         out_idx_o,
`ifdef CDC_4PHASE_ARB_STATS_EN
    input  logic                        clr_stats_i,
    output logic [NumReq*16-1:0]        stat_cnt_o,
`endif
    output logic                        busy_o
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic [IdxWidth-1:0]  rr_q, rr_d;
    logic [IdxWidth-1:0]  win_idx;
    logic [IdxWidth:0]    scan_idx;
    logic                 win_found;
    logic                 can_accept;
    logic                 accept;
    logic [DataWidth-1:0] req_data_arr [NumReq];

    for (genvar k = 0; k < NumReq; k++) begin : g_unpack
        assign req_data_arr[k] = req_data_i[k*DataWidth +: DataWidth];
    end

    // Find the first valid requester scanning from rr_q upward with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            scan_idx = {1'b0, rr_q} + (IdxWidth+1)'(i);
            if (scan_idx >= (IdxWidth+1)'(NumReq)) begin
                scan_idx = scan_idx - (IdxWidth+1)'(NumReq);
            end
            if (!win_found && req_valid_i[scan_idx[IdxWidth-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IdxWidth-1:0];
            end
        end
    end

    // Output register is free when empty or when its item is consumed this cycle.
    assign can_accept  = en_i & ((state_q == StEmpty) | out_ready_i);
    assign accept      = can_accept & win_found & ~rst_i;
    assign req_ready_o = accept ? (NumReq'(1) << win_idx) : '0;

    // Next-state: load a new winner, drain to empty, or hold the presented item stable.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        if (accept) begin
            state_d = StFull;
            data_d  = req_data_arr[win_idx];
            idx_d   = win_idx;
            rr_d    = (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + 1'b1;
        end else if ((state_q == StFull) && out_ready_i) begin
            state_d = StEmpty;
        end
    end

    // FSM and registered outputs; reset drops any held item.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            data_q  <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
        end
    end

    assign out_valid_o = (state_q == StFull);
    assign busy_o      = (state_q == StFull);
    assign out_data_o  = data_q;
    assign out_idx_o   = idx_q;

`ifdef CDC_4PHASE_ARB_STATS_EN
    logic [15:0] cnt_q [NumReq];
    logic [15:0] cnt_d [NumReq];

    // Saturating accept counters; clear wins over a same-cycle increment.
    always_comb begin
        for (int unsigned k = 0; k < NumReq; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_stats_i) begin
                cnt_d[k] = '0;
            end else if (req_valid_i[k] && req_ready_o[k] && (cnt_q[k] != 16'hFFFF)) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (rst_i) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    for (genvar k = 0; k < NumReq; k++) begin : g_stat
        assign stat_cnt_o[k*16 +: 16] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_cdc_4phase_src_arbiter.sv
// Scoreboard bench for cdc_4phase_src_arbiter (NumReq = 4, DataWidth = 32).
module tb_cdc_4phase_src_arbiter;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic         out_ready_i;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic         out_valid;
    logic         busy;
    logic [31:0]  out_data;
    logic [1:0]   out_idx;
`ifdef CDC_4PHASE_ARB_STATS_EN
    logic         clr_stats;
    logic [63:0]  stat_cnt;
`endif

    always #5 clk = ~clk;

    cdc_4phase_src_arbiter #(
        .NumReq    (4),
        .DataWidth (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
`ifdef CDC_4PHASE_ARB_STATS_EN
        .clr_stats_i (clr_stats),
        .stat_cnt_o  (stat_cnt),
`endif
        .busy_o      (busy)
    );

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
    } item_t;

    item_t      exp_q[$];   // expected output order, hand-computed
    item_t      src_q[$];   // pending requester items, tagged with requester
    int         tests = 0;
    int         fails = 0;
    logic [3:0] hs;
    logic [3:0] prev_v = '0;
    logic [3:0] prev_r = '0;
    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic push_src(input int k, input logic [31:0] d);
        item_t it;
        it.idx  = 2'(k);
        it.data = d;
        src_q.push_back(it);
    endtask

    task automatic push_exp(input int k, input logic [31:0] d);
        item_t it;
        it.idx  = 2'(k);
        it.data = d;
        exp_q.push_back(it);
    endtask

    // Drive each requester with its oldest pending item.
    task automatic present();
        req_valid = '0;
        req_data  = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < src_q.size(); j++) begin
                if (src_q[j].idx == 2'(k)) begin
                    req_valid[k]         = 1'b1;
                    req_data[k*32 +: 32] = src_q[j].data;
                    break;
                end
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        hs = req_valid & req_ready;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) begin
                for (int j = 0; j < src_q.size(); j++) begin
                    if (src_q[j].idx == 2'(k)) begin
                        src_q.delete(j);
                        break;
                    end
                end
            end
        end
        present();
    endtask

    task automatic step();
        to_neg();
        to_pos();
    endtask

    // Monitor: every consumed output item is compared against the scoreboard.
    always @(negedge clk) begin
        item_t e;
        if (!rst_i && out_valid && out_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_unexpected: got idx %0d data %h, required no item", out_idx,
                         out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_idx", 64'(out_idx), 64'(e.idx));
                check("out_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    // Requesters must never withdraw valid before their handshake.
    always @(negedge clk) begin
        if (!rst_i) begin
            for (int k = 0; k < 4; k++) begin
                if (prev_v[k] && !prev_r[k] && !req_valid[k]) begin
                    fails++;
                    $display("FAIL protocol_drop: requester %0d dropped valid, required held", k);
                end
            end
        end
        prev_v <= req_valid;
        prev_r <= req_ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        en_i        = 1'b1;
        out_ready_i = 1'b0;
`ifdef CDC_4PHASE_ARB_STATS_EN
        clr_stats   = 1'b0;
`endif
        present();
        step();
        step();
        rst_i = 1'b0;

        // Reset then idle
        to_neg();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        to_pos();

        // Round-robin order with all requesters valid
        out_ready_i = 1'b1;
        push_src(0, 32'hA000_0000);
        push_src(0, 32'hA000_0000);
        push_src(1, 32'hA000_0001);
        push_src(2, 32'hA000_0002);
        push_src(3, 32'hA000_0003);
        push_exp(0, 32'hA000_0000);
        push_exp(1, 32'hA000_0001);
        push_exp(2, 32'hA000_0002);
        push_exp(3, 32'hA000_0003);
        push_exp(0, 32'hA000_0000);
        present();
        for (int i = 0; i < 5; i++) begin
            to_neg();
            check("rr_ready", 64'(req_ready), 64'(rr_exp[i]));
            if (i > 0) check("rr_out_valid", 64'(out_valid), 64'd1);
            to_pos();
        end
        to_neg();
        check("rr_last_valid", 64'(out_valid), 64'd1);
        check("rr_last_ready", 64'(req_ready), 64'd0);
        to_pos();
        to_neg();
        check("rr_drained", 64'(out_valid), 64'd0);
        to_pos();

        // Backpressure: item held stable while out_ready_i is low
        out_ready_i = 1'b0;
        push_src(2, 32'hDEAD_BEEF);
        push_exp(2, 32'hDEAD_BEEF);
        present();
        to_neg();
        check("bp_grant", 64'(req_ready), 64'b0100);
        to_pos();
        for (int i = 0; i < 5; i++) begin
            to_neg();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_idx", 64'(out_idx), 64'd2);
            check("bp_data", 64'(out_data), 64'hDEAD_BEEF);
            check("bp_ready", 64'(req_ready), 64'd0);
            to_pos();
        end
        out_ready_i = 1'b1;
        step();
        to_neg();
        check("bp_empty", 64'(out_valid), 64'd0);
        to_pos();

        // Pointer wrap and skip (pointer now 3)
        push_src(1, 32'h1111_0001);
        push_exp(1, 32'h1111_0001);
        present();
        to_neg();
        check("wrap_grant1", 64'(req_ready), 64'b0010);
        to_pos();
        push_src(3, 32'h3333_0003);
        push_src(0, 32'h0000_0A0A);
        push_exp(3, 32'h3333_0003);
        push_exp(0, 32'h0000_0A0A);
        present();
        to_neg();
        check("wrap_grant3", 64'(req_ready), 64'b1000);
        to_pos();
        to_neg();
        check("wrap_grant0", 64'(req_ready), 64'b0001);
        to_pos();
        to_neg();
        check("wrap_no_grant", 64'(req_ready), 64'd0);
        to_pos();
        to_neg();
        check("wrap_empty", 64'(out_valid), 64'd0);
        to_pos();

        // Enable low blocks grants
        en_i = 1'b0;
        push_src(0, 32'h0E0E_0000);
        push_exp(0, 32'h0E0E_0000);
        present();
        for (int i = 0; i < 3; i++) begin
            to_neg();
            check("en_low_ready", 64'(req_ready), 64'd0);
            check("en_low_valid", 64'(out_valid), 64'd0);
            to_pos();
        end
        en_i = 1'b1;
        to_neg();
        check("en_high_grant", 64'(req_ready), 64'b0001);
        to_pos();
        out_ready_i = 1'b0;
        to_neg();
        check("en_full_valid", 64'(out_valid), 64'd1);
        check("en_full_idx", 64'(out_idx), 64'd0);
        to_pos();

        // Reset while FULL drops the held item and clears the pointer
        rst_i = 1'b1;
        push_src(0, 32'hC000_0000);
        push_src(1, 32'hC000_0001);
        push_src(2, 32'hC000_0002);
        present();
        to_neg();
        check("rst_mid_ready", 64'(req_ready), 64'd0);
        to_pos();
        void'(exp_q.pop_front());
        push_exp(0, 32'hC000_0000);
        push_exp(1, 32'hC000_0001);
        push_exp(2, 32'hC000_0002);
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        to_neg();
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_idx", 64'(out_idx), 64'd0);
        check("rst_mid_data", 64'(out_data), 64'd0);
        check("rst_mid_rr0", 64'(req_ready), 64'b0001);
        to_pos();
        to_neg();
        check("rst_mid_rr1", 64'(req_ready), 64'b0010);
        to_pos();
        to_neg();
        check("rst_mid_rr2", 64'(req_ready), 64'b0100);
        to_pos();
        step();
        to_neg();
        check("rst_mid_drained", 64'(out_valid), 64'd0);
        to_pos();

`ifdef CDC_4PHASE_ARB_STATS_EN
        // Accept counters: clear, count, then clear coincident with an accept
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        to_neg();
        check("stat_cleared", stat_cnt, 64'd0);
        to_pos();
        push_src(1, 32'hB000_0001);
        push_src(1, 32'hB000_0002);
        push_src(1, 32'hB000_0003);
        push_src(3, 32'hB000_0004);
        push_exp(3, 32'hB000_0004);
        push_exp(1, 32'hB000_0001);
        push_exp(1, 32'hB000_0002);
        push_exp(1, 32'hB000_0003);
        present();
        for (int i = 0; i < 5; i++) step();
        to_neg();
        check("stat_counts", stat_cnt, {16'd1, 16'd0, 16'd3, 16'd0});
        to_pos();
        push_src(1, 32'hB000_0005);
        push_exp(1, 32'hB000_0005);
        clr_stats = 1'b1;
        present();
        to_neg();
        check("stat_clr_grant", 64'(req_ready), 64'b0010);
        to_pos();
        clr_stats = 1'b0;
        to_neg();
        check("stat_clr_priority", stat_cnt, 64'd0);
        to_pos();
        step();
`endif

        step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("sources_drained", 64'(src_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
